// File: rtl/muldiv_sched_pkg.sv
// Shared definitions for the HI/LO multiply/divide scheduler: width, op codes, FSM states.
package muldiv_sched_pkg;

   localparam int unsigned MD_W = 32;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MUL     = 2'd1,
      S_DIV_RUN = 2'd2,
      S_DONE    = 2'd3
   } md_state_e;

endpackage

// File: rtl/muldiv_sched_div_iter.sv
// Restoring shift-subtract divider on unsigned magnitudes, one quotient bit per cycle.
module div_iter
   import muldiv_sched_pkg::*;
#(
   parameter int unsigned W = MD_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic         abort_i,
   input  logic [W-1:0] dividend_i,
   input  logic [W-1:0] divisor_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [W-1:0] quot_o,
   output logic [W-1:0] rem_o
);

   localparam int unsigned CW = $clog2(W) + 1;

   logic [W-1:0]  dvd_q, dvd_d;
   logic [W-1:0]  dvs_q, dvs_d;
   logic [W-1:0]  rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic [W:0]    shifted;
   logic [W:0]    diff;

   // done_o marks the cycle in which the final quotient bit is produced
   assign done_o = busy_q && (cnt_q == CW'(W - 1));
   assign busy_o = busy_q;
   assign quot_o = dvd_q;
   assign rem_o  = rem_q;

   always_comb begin
      shifted = {rem_q, dvd_q[W-1]};
      diff    = shifted - {1'b0, dvs_q};
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      if (abort_i) begin
         busy_d = 1'b0;
      end else if (start_i) begin
         dvd_d  = dividend_i;
         dvs_d  = divisor_i;
         rem_d  = '0;
         cnt_d  = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         rem_d = diff[W] ? shifted[W-1:0] : diff[W-1:0];
         dvd_d = {dvd_q[W-2:0], ~diff[W]};
         cnt_d = cnt_q + 1'b1;
         if (done_o) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_q  <= '0;
         dvs_q  <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         dvd_q  <= dvd_d;
         dvs_q  <= dvs_d;
         rem_q  <= rem_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/muldiv_sched.sv
// EX-stage HI/LO scheduler: single-cycle multiply, iterative divide, MTHI/MTLO pass-through.
module muldiv_sched
   import muldiv_sched_pkg::*;
#(
   parameter int unsigned W = MD_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid_i,
   input  logic [2:0]   op_i,
   input  logic [W-1:0] opa_i,
   input  logic [W-1:0] opb_i,
   input  logic [W-1:0] hi_i,
   input  logic [W-1:0] lo_i,
   input  logic         flush_i,
   output logic         stall_o,
   output logic         hilo_we_o,
   output logic [W-1:0] hi_o,
   output logic [W-1:0] lo_o
);

   md_state_e      state_q, state_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic           sgn_q, sgn_d;
   logic           qneg_q, qneg_d;
   logic           rneg_q, rneg_d;
   logic           dz_q, dz_d;

   logic           is_mul, is_div, op_signed, accept, div_start;
   logic [W-1:0]   amag, bmag;
   logic [2*W-1:0] ext_a, ext_b, prod;
   logic           div_busy, div_done;
   logic [W-1:0]   quot, rem;

   assign is_mul    = (op_i == OP_MULT) || (op_i == OP_MULTU);
   assign is_div    = (op_i == OP_DIV)  || (op_i == OP_DIVU);
   assign op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
   assign accept    = (state_q == S_IDLE) && valid_i && !flush_i && (is_mul || is_div);
   assign div_start = accept && is_div && (opb_i != '0);
   assign amag      = (op_signed && opa_i[W-1]) ? -opa_i : opa_i;
   assign bmag      = (op_signed && opb_i[W-1]) ? -opb_i : opb_i;

   assign ext_a = sgn_q ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
   assign ext_b = sgn_q ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};
   assign prod  = ext_a * ext_b;

   div_iter #(.W(W)) u_div_iter (
      .clk       (clk),
      .rst       (rst),
      .start_i   (div_start),
      .abort_i   (flush_i),
      .dividend_i(amag),
      .divisor_i (bmag),
      .busy_o    (div_busy),
      .done_o    (div_done),
      .quot_o    (quot),
      .rem_o     (rem)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               a_d    = opa_i;
               b_d    = opb_i;
               sgn_d  = op_signed;
               qneg_d = op_signed && (opa_i[W-1] ^ opb_i[W-1]);
               rneg_d = op_signed && opa_i[W-1];
               dz_d   = (opb_i == '0);
               if (is_mul)              state_d = S_MUL;
               else if (opb_i == '0)    state_d = S_DONE;
               else                     state_d = S_DIV_RUN;
            end
         end
         S_MUL:     state_d = S_IDLE;
         S_DIV_RUN: if (div_done) state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
      endcase
      if (flush_i && state_q != S_IDLE) state_d = S_IDLE;
   end

   always_comb begin
      stall_o   = 1'b0;
      hilo_we_o = 1'b0;
      hi_o      = '0;
      lo_o      = '0;
      if (!rst && !flush_i) begin
         unique case (state_q)
            S_IDLE: begin
               if (valid_i) begin
                  if (is_mul || is_div) begin
                     stall_o = 1'b1;
                  end else if (op_i == OP_MTHI) begin
                     hilo_we_o = 1'b1;
                     hi_o      = opa_i;
                     lo_o      = lo_i;
                  end else if (op_i == OP_MTLO) begin
                     hilo_we_o = 1'b1;
                     hi_o      = hi_i;
                     lo_o      = opa_i;
                  end
               end
            end
            S_MUL: begin
               hilo_we_o = 1'b1;
               hi_o      = prod[2*W-1:W];
               lo_o      = prod[W-1:0];
            end
            S_DIV_RUN: stall_o = 1'b1;
            S_DONE: begin
               hilo_we_o = 1'b1;
               if (dz_q) begin
                  hi_o = a_q;
                  lo_o = '1;
               end else begin
                  hi_o = rneg_q ? -rem  : rem;
                  lo_o = qneg_q ? -quot : quot;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed plus randomized checks of muldiv_sched against an arithmetic reference model.
module tb_muldiv_sched;
   import muldiv_sched_pkg::*;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         valid_i;
   logic [2:0]   op_i;
   logic [W-1:0] opa_i, opb_i, hi_i, lo_i;
   logic         flush_i;
   logic         stall_o, hilo_we_o;
   logic [W-1:0] hi_o, lo_o;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   muldiv_sched #(.W(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .valid_i  (valid_i),
      .op_i     (op_i),
      .opa_i    (opa_i),
      .opb_i    (opb_i),
      .hi_i     (hi_i),
      .lo_i     (lo_i),
      .flush_i  (flush_i),
      .stall_o  (stall_o),
      .hilo_we_o(hilo_we_o),
      .hi_o     (hi_o),
      .lo_o     (lo_o)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: HI/LO results and cycles from acceptance to the write.
   task automatic model(input logic [2:0] op, input logic [W-1:0] a, b, hin, lin,
                        output logic [W-1:0] eh, el, output int unsigned lat);
      longint          sa, sb, sp, sq, sr;
      longint unsigned up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      eh = '0; el = '0; lat = 0;
      case (op)
         OP_MULT:  begin sp = sa * sb; eh = sp[63:32]; el = sp[31:0]; lat = 1; end
         OP_MULTU: begin up = {32'd0, a} * {32'd0, b}; eh = up[63:32]; el = up[31:0]; lat = 1; end
         OP_DIV: begin
            if (b == 0) begin eh = a; el = '1; lat = 1; end
            else begin sq = sa / sb; sr = sa % sb; eh = sr[31:0]; el = sq[31:0]; lat = W + 1; end
         end
         OP_DIVU: begin
            if (b == 0) begin eh = a; el = '1; lat = 1; end
            else begin eh = a % b; el = a / b; lat = W + 1; end
         end
         OP_MTHI: begin eh = a;   el = lin; end
         OP_MTLO: begin eh = hin; el = a;   end
         default: ;
      endcase
   endtask

   task automatic drive_idle();
      @(posedge clk); #1;
      valid_i = 1'b0; op_i = OP_NOP; flush_i = 1'b0;
   endtask

   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b, hin, lin);
      logic [W-1:0] eh, el;
      int unsigned  lat, n, stalls;
      model(op, a, b, hin, lin, eh, el, lat);
      @(posedge clk); #1;
      valid_i = 1'b1; op_i = op; opa_i = a; opb_i = b; hi_i = hin; lo_i = lin; flush_i = 1'b0;
      @(negedge clk);
      if (op == OP_MTHI || op == OP_MTLO) begin
         chk("mthilo", {stall_o, hilo_we_o, hi_o, lo_o}, {1'b0, 1'b1, eh, el});
      end else begin
         n = 0; stalls = 0;
         while (n <= W + 4 && hilo_we_o !== 1'b1) begin
            if (stall_o === 1'b1) stalls++;
            n++;
            @(posedge clk); #1;
            // instruction inputs must be ignored while busy
            valid_i = 1'($urandom_range(0, 1)); op_i = 3'($urandom);
            opa_i = $urandom; opb_i = $urandom; hi_i = $urandom; lo_i = $urandom;
            @(negedge clk);
         end
         chk("latency", 128'(n), 128'(lat));
         chk("stall_cycles", 128'(stalls), 128'(lat));
         chk("result", {stall_o, hilo_we_o, hi_o, lo_o}, {2'b01, eh, el});
      end
      drive_idle();
      @(negedge clk);
      chk("idle_after", {stall_o, hilo_we_o, hi_o, lo_o}, '0);
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return W'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [2:0]   rop;
      logic [W-1:0] ra, rb;
      logic         bad;
      int unsigned  n;

      rst = 1'b1; valid_i = 1'b1; op_i = OP_MULT; opa_i = 3; opb_i = 4;
      hi_i = '0; lo_i = '0; flush_i = 1'b1;
      @(negedge clk);
      chk("reset_outputs", {stall_o, hilo_we_o, hi_o, lo_o}, '0);
      @(posedge clk); #1; flush_i = 1'b0;
      @(negedge clk);
      chk("reset_over_valid", {stall_o, hilo_we_o, hi_o, lo_o}, '0);
      @(posedge clk); #1; rst = 1'b0; valid_i = 1'b0; op_i = OP_NOP;
      @(negedge clk);
      chk("idle_after_reset", {stall_o, hilo_we_o, hi_o, lo_o}, '0);

      run_op(OP_DIVU,  32'd100,        32'd7,        '0, '0);
      run_op(OP_DIV,   -32'sd7,        32'd2,        '0, '0);
      run_op(OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF, '0, '0);
      run_op(OP_MULT,  32'hFFFF_FFFF,  32'd2,        '0, '0);
      run_op(OP_MULTU, 32'hFFFF_FFFF,  32'd2,        '0, '0);
      run_op(OP_DIVU,  32'd5,          32'd0,        '0, '0);
      run_op(OP_DIV,   -32'sd5,        32'd0,        '0, '0);
      run_op(OP_DIV,   32'd7,          -32'sd2,      '0, '0);
      run_op(OP_MTLO,  32'h1234,       32'd0,        32'hAA, 32'h55);
      run_op(OP_MTHI,  32'h9876,       32'd0,        32'hAA, 32'h55);

      // MTLO presented while a divide runs must not write
      @(posedge clk); #1;
      valid_i = 1'b1; op_i = OP_DIVU; opa_i = 100; opb_i = 7;
      @(posedge clk); #1;
      op_i = OP_MTLO; opa_i = 32'h1234; hi_i = 32'hAA;
      @(negedge clk);
      chk("mtlo_in_div_run", {stall_o, hilo_we_o}, 2'b10);
      drive_idle();
      n = 0;
      @(negedge clk);
      while (n < W + 4 && hilo_we_o !== 1'b1) begin
         n++;
         @(negedge clk);
      end
      chk("div_after_mtlo", {hilo_we_o, hi_o, lo_o}, {1'b1, 32'd2, 32'd14});

      // flush at cycle 10 of a divide
      @(posedge clk); #1;
      valid_i = 1'b1; op_i = OP_DIV; opa_i = 1000; opb_i = 3;
      bad = 1'b0;
      for (int c = 1; c < 10; c++) begin
         @(posedge clk); #1; valid_i = 1'b0;
         @(negedge clk);
         if (hilo_we_o !== 1'b0 || stall_o !== 1'b1) bad = 1'b1;
      end
      chk("div_before_flush", 128'(bad), '0);
      @(posedge clk); #1; flush_i = 1'b1;
      @(negedge clk);
      chk("flush_cycle", {stall_o, hilo_we_o, hi_o, lo_o}, '0);
      drive_idle();
      bad = 1'b0;
      for (int c = 0; c < W + 4; c++) begin
         @(negedge clk);
         if (hilo_we_o !== 1'b0 || stall_o !== 1'b0) bad = 1'b1;
         @(posedge clk); #1;
      end
      chk("no_write_after_flush", 128'(bad), '0);
      run_op(OP_MULT, 32'd3, 32'd4, '0, '0);

      // flush in IDLE suppresses acceptance and MT writes
      @(posedge clk); #1;
      valid_i = 1'b1; op_i = OP_MULT; opa_i = 5; opb_i = 6; flush_i = 1'b1;
      @(negedge clk);
      chk("flush_idle_mult", {stall_o, hilo_we_o}, 2'b00);
      @(posedge clk); #1; op_i = OP_MTHI;
      @(negedge clk);
      chk("flush_idle_mthi_nomul", {stall_o, hilo_we_o, hi_o, lo_o}, '0);
      drive_idle();
      @(negedge clk);
      chk("flush_idle_after", {stall_o, hilo_we_o}, 2'b00);

      // flush while in MUL drops the write
      @(posedge clk); #1;
      valid_i = 1'b1; op_i = OP_MULTU; opa_i = 7; opb_i = 8;
      @(posedge clk); #1; valid_i = 1'b0; flush_i = 1'b1;
      @(negedge clk);
      chk("flush_in_mul", {stall_o, hilo_we_o}, 2'b00);
      drive_idle();

      // reset mid-divide aborts without a write
      @(posedge clk); #1;
      valid_i = 1'b1; op_i = OP_DIVU; opa_i = 99; opb_i = 4;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1; valid_i = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("reset_in_div_run", {stall_o, hilo_we_o, hi_o, lo_o}, '0);
      @(posedge clk); #1; rst = 1'b0;
      bad = 1'b0;
      for (int c = 0; c < W + 4; c++) begin
         @(negedge clk);
         if (hilo_we_o !== 1'b0 || stall_o !== 1'b0) bad = 1'b1;
         @(posedge clk); #1;
      end
      chk("no_write_after_reset", 128'(bad), '0);

      for (int i = 0; i < 60; i++) begin
         rop = 3'($urandom_range(1, 6));
         ra  = pick_operand();
         rb  = pick_operand();
         run_op(rop, ra, rb, $urandom, $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_sched.md
MULDIV_SCHED -- requirements
Module: muldiv_sched

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning the operand and HI/LO width.
REQ-002 The block SHALL have port clk, input, 1 bit, meaning the system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, meaning reset; synchronous, active-high.
REQ-004 The block SHALL have port valid_i, input, 1 bit, meaning an EX-stage instruction is presenting op_i.
REQ-005 The block SHALL have port op_i, input, 3 bits, meaning NOP, MULT, MULTU, DIV, DIVU, MTHI or MTLO.
REQ-006 The block SHALL have ports opa_i and opb_i, input, W bits each, meaning rs and rt operands.
REQ-007 The block SHALL have ports hi_i and lo_i, input, W bits each, meaning the current HI/LO contents after forwarding.
REQ-008 The block SHALL have port flush_i, input, 1 bit, meaning annul the in-flight operation.
REQ-009 The block SHALL have port stall_o, output, 1 bit, meaning hold the pipeline at EX.
REQ-010 The block SHALL have port hilo_we_o, output, 1 bit, meaning HI/LO write strobe.
REQ-011 The block SHALL have ports hi_o and lo_o, output, W bits each, meaning HI/LO write data.

Function
REQ-012 The block SHALL implement FSM states IDLE, MUL, DIV_RUN and DONE.
REQ-013 In IDLE, a MULT/MULTU/DIV/DIVU with valid_i=1 SHALL be accepted: stall_o=1 combinationally in the same cycle, and operands latched at the edge.
REQ-014 Acceptance of MULT/MULTU SHALL move the FSM to MUL.
REQ-015 In MUL, the block SHALL output hi_o/lo_o = upper/lower W bits of the 2W-bit product (signed for MULT), with hilo_we_o=1 and stall_o=0, then return to IDLE.
REQ-016 Acceptance of DIV/DIVU with opb_i!=0 SHALL latch the magnitudes and result signs, then move to DIV_RUN for exactly W cycles of restoring shift-subtract, one quotient bit per cycle, with stall_o=1.
REQ-017 After the last iteration the FSM SHALL enter DONE: hilo_we_o=1, stall_o=0, lo_o=quotient, hi_o=remainder, then return to IDLE.
REQ-018 For signed division, the quotient sign SHALL be sign(a)^sign(b) and the remainder sign SHALL be sign(a) (truncating division).
REQ-019 Signed overflow (0x80000000/-1) SHALL give lo_o=0x80000000 and hi_o=0.
REQ-020 Divide by zero SHALL skip DIV_RUN and go directly to DONE, with hi_o=opa latched and lo_o=all-ones (both signed and unsigned).
REQ-021 MTHI in IDLE SHALL be combinational with no stall: hilo_we_o=1, hi_o=opa_i, lo_o=lo_i.
REQ-022 MTLO in IDLE SHALL be combinational with no stall: hilo_we_o=1, hi_o=hi_i, lo_o=opa_i.
REQ-023 valid_i/op_i SHALL be ignored in MUL, DIV_RUN and DONE; during those states the presented instruction is the one already accepted.
REQ-024 flush_i=1 in any non-IDLE state SHALL force IDLE at the next edge, with hilo_we_o=0 and stall_o=0 in that cycle.
REQ-025 flush_i=1 in IDLE SHALL suppress acceptance and MTHI/MTLO writes.
REQ-026 Outside REQ-015/017/021/022, hilo_we_o SHALL be 0 and hi_o/lo_o SHALL be 0.
REQ-027 Latency SHALL be: MULT = accept + 1 cycle; DIV (nonzero divisor) = accept + W+1 cycles; div-by-zero = accept + 1 cycle.

Reset
REQ-028 rst=1 SHALL put the FSM in IDLE and clear the iteration counter, operand, partial-remainder and quotient registers.
REQ-029 During reset, stall_o, hilo_we_o, hi_o and lo_o SHALL be 0; rst SHALL take precedence over flush_i and valid_i.
REQ-030 Reset during DIV_RUN SHALL abort with no write.

Structure
REQ-031 The op_i encodings, FSM state codes and W SHALL be defined in the shared defines header, not locally.
REQ-032 The shift-subtract iteration (partial remainder, quotient and counter registers, with start/busy/done signals) SHALL be one sub-module, div_iter.
REQ-033 Sign fix-up and FSM logic SHALL remain in muldiv_sched.

Verification
REQ-034 DIVU 100/7 -> stall_o=1 for 33 cycles; at cycle 33 hilo_we_o=1, lo_o=14, hi_o=2.
REQ-035 DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
REQ-036 MULT 0xFFFFFFFF*2 -> cycle 1: hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE; MULTU same operands -> hi_o=1, lo_o=0xFFFFFFFE.
REQ-037 DIVU 5/0 -> cycle 1: hilo_we_o=1, hi_o=5, lo_o=0xFFFFFFFF.
REQ-038 DIV accepted, flush_i pulsed at cycle 10 -> no hilo_we_o pulse, stall_o=0 from cycle 10; a following MULT 3*4 gives lo_o=12.
REQ-039 MTLO opa=0x1234 with hi_i=0xAA in IDLE -> same cycle hilo_we_o=1, hi_o=0xAA, lo_o=0x1234, stall_o=0; the same op presented during DIV_RUN -> no write.
